// File: rtl/frame_sched.sv
// -----------------------------------------------------------------------------
// frame_sched -- frame-synchronous game-update scheduler
//
// Purpose:
//   Asks the game logic for a new object state once every FRAME_DIV frames.
//   The request starts on the falling edge of VS. The answer (upd_ack plus the
//   *_in buses) is committed to the renderer-facing outputs only while the
//   display is in blanking. The committed positions therefore never change
//   inside a visible frame.
//   If blanking ends before the answer arrives, the request is abandoned.
//   The 'late' output pulses and a saturating miss counter increments.
//
// Parameters:
//   FRAME_DIV  request period in frames (1..255)
//   LATE_W     width of the saturating late counter
//
// Ports:
//   CLOCK_50   in   1       system clock, rising edge
//   reset      in   1       synchronous active-low reset
//   VS         in   1       active-low vertical sync
//   blank      in   1       high outside the visible area
//   upd_ack    in   1       game logic: *_in buses hold the next state
//   pause      in   1       (only with FRAME_SCHED_PAUSE_EN) suppress requests
//   ball_x_in  in   10      next ball x
//   ball_y_in  in   9       next ball y
//   pad_l_in   in   9       next left paddle position
//   pad_r_in   in   9       next right paddle position
//   upd_req    out  1       update request to game logic
//   ball_x     out  10      committed ball x
//   ball_y     out  9       committed ball y
//   pad_l      out  9       committed left paddle
//   pad_r      out  9       committed right paddle
//   frame_cnt  out  16      number of committed updates (wraps)
//   late       out  1       one-cycle pulse on a missed deadline
//   late_cnt   out  LATE_W  saturating count of missed deadlines
//
// Configuration macro:
//   FRAME_SCHED_PAUSE_EN  adds the 'pause' input. While pause is high, frame
//                         edges seen in IDLE neither start a request nor
//                         advance the divider.
// -----------------------------------------------------------------------------
module frame_sched #(
    parameter int FRAME_DIV = 1,
    parameter int LATE_W    = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              VS,
    input  logic              blank,
    input  logic              upd_ack,
`ifdef FRAME_SCHED_PAUSE_EN
    input  logic              pause,
`endif
    input  logic [9:0]        ball_x_in,
    input  logic [8:0]        ball_y_in,
    input  logic [8:0]        pad_l_in,
    input  logic [8:0]        pad_r_in,
    output logic              upd_req,
    output logic [9:0]        ball_x,
    output logic [8:0]        ball_y,
    output logic [8:0]        pad_l,
    output logic [8:0]        pad_r,
    output logic [15:0]       frame_cnt,
    output logic              late,
    output logic [LATE_W-1:0] late_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Last divider value; the edge that finds the divider here starts a request.
    localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

    // Positions shown before the first commit: ball centred, paddles mid-height.
    localparam logic [9:0] BALL_X_RST = 10'd320;
    localparam logic [8:0] BALL_Y_RST = 9'd240;
    localparam logic [8:0] PAD_RST    = 9'd208;

    state_t      state_r;
    logic [7:0]  div_cnt_r;
    logic        vs_d_r;
    logic        frame_edge_s;
    logic        edge_eff_s;

    // Saturating increment: once all ones, the miss counter stays there.
    function automatic logic [LATE_W-1:0] sat_inc(input logic [LATE_W-1:0] v);
        logic [LATE_W-1:0] r;
        if (v == {LATE_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + LATE_W'(1);
        end
        return r;
    endfunction

    // Frame edge = VS falling. With pause compiled in, a paused edge is masked.
    always_comb begin
        frame_edge_s = vs_d_r & ~VS;
`ifdef FRAME_SCHED_PAUSE_EN
        if (pause) begin
            edge_eff_s = 1'b0;
        end else begin
            edge_eff_s = frame_edge_s;
        end
`else
        edge_eff_s = frame_edge_s;
`endif
    end

    // Scheduler FSM with registered request, late pulse, counters and outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_r   <= IDLE;
            div_cnt_r <= 8'd0;
            vs_d_r    <= 1'b1;
            upd_req   <= 1'b0;
            late      <= 1'b0;
            late_cnt  <= {LATE_W{1'b0}};
            frame_cnt <= 16'd0;
            ball_x    <= BALL_X_RST;
            ball_y    <= BALL_Y_RST;
            pad_l     <= PAD_RST;
            pad_r     <= PAD_RST;
        end else begin
            vs_d_r <= VS;
            late   <= 1'b0;
            case (state_r)
                IDLE: begin
                    // upd_ack is deliberately not looked at here.
                    upd_req <= 1'b0;
                    if (edge_eff_s) begin
                        if (div_cnt_r == DIV_LAST) begin
                            div_cnt_r <= 8'd0;
                            state_r   <= REQ;
                            upd_req   <= 1'b1;
                        end else begin
                            div_cnt_r <= div_cnt_r + 8'd1;
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r;
                    end
                end
                REQ: begin
                    // Frame edges are ignored here. The end of blanking is
                    // checked before upd_ack, so an ack that arrives as
                    // blanking ends still counts as a miss.
                    if (!blank) begin
                        upd_req  <= 1'b0;
                        late     <= 1'b1;
                        late_cnt <= sat_inc(late_cnt);
                        state_r  <= IDLE;
                    end else if (upd_ack) begin
                        ball_x    <= ball_x_in;
                        ball_y    <= ball_y_in;
                        pad_l     <= pad_l_in;
                        pad_r     <= pad_r_in;
                        frame_cnt <= frame_cnt + 16'd1;
                        upd_req   <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        upd_req <= 1'b1;
                    end
                end
                default: begin
                    upd_req <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/frame_sched.md
FRAME_SCHED -- requirements
Module: frame_sched

Interface
REQ-001 Parameter FRAME_DIV, default 1, meaning: issue one game-update request every FRAME_DIV frames (legal range 1..255).
REQ-002 Parameter LATE_W, default 8, meaning: width of the saturating late-update counter.
REQ-003 CLOCK_50  input  1  system clock; all logic on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 VS  input  1  active-low vertical sync from the VGA timing generator.
REQ-006 blank  input  1  high when the current pixel is outside the visible area.
REQ-007 upd_req  output  1  request to game logic to compute the next object state.
REQ-008 upd_ack  input  1  game logic asserts this when the *_in buses hold the next state.
REQ-009 ball_x_in / ball_y_in / pad_l_in / pad_r_in  input  10/9/9/9  next-state positions from game logic.
REQ-010 ball_x / ball_y / pad_l / pad_r  output  10/9/9/9  committed positions fed to the renderer; stable for a whole displayed frame.
REQ-011 frame_cnt  output  16  count of committed updates.
REQ-012 late  output  1  one-cycle pulse when an update misses its deadline.
REQ-013 late_cnt  output  LATE_W  saturating count of missed deadlines.

Function
REQ-014 Frame edge: VS registered into vs_d each cycle; frame edge = (vs_d==1 && VS==0).
REQ-015 The FSM SHALL have states IDLE, REQ; divider div_cnt (8 bit) counts frame edges 0..FRAME_DIV-1, then wraps to 0.
REQ-016 IDLE: on a frame edge with div_cnt==FRAME_DIV-1, the next state SHALL be REQ with upd_req=1 from the following cycle; any other frame edge only advances div_cnt.
REQ-017 REQ: upd_req SHALL hold 1 until exit; frame edges in REQ are ignored and do not advance div_cnt.
REQ-018 Commit: in REQ with upd_ack==1 and blank==1, on that edge the outputs SHALL load the *_in values, frame_cnt SHALL increment (0xFFFF wraps to 0), upd_req SHALL drop, state SHALL go to IDLE; new outputs are visible 1 cycle after ack sampled.
REQ-019 Deadline: in REQ with blank==0, on that edge upd_req SHALL drop, late SHALL pulse 1 for exactly one cycle, late_cnt SHALL increment and saturate at all-ones, outputs SHALL hold their old values, state SHALL go to IDLE.
REQ-020 If upd_ack==1 and blank==0 in the same cycle, the deadline rule SHALL win; no commit.
REQ-021 upd_ack SHALL be ignored in IDLE; committed outputs SHALL change only on a commit or reset.
REQ-022 FRAME_DIV==1: every frame edge in IDLE SHALL start a request.

Reset
REQ-023 With reset==0 at a clock edge: state=IDLE, upd_req=0, late=0, late_cnt=0, frame_cnt=0, div_cnt=0, vs_d=1.
REQ-024 Reset outputs: ball_x=320, ball_y=240, pad_l=208, pad_r=208.
REQ-025 Reset asserted in REQ SHALL drop upd_req the next cycle with no commit and no late pulse.

Configuration
REQ-026 With macro FRAME_SCHED_PAUSE_EN defined, an input pause (1 bit) SHALL exist; pause==1 on a frame edge in IDLE suppresses the request and freezes div_cnt; pause has no effect in REQ.
REQ-027 Without FRAME_SCHED_PAUSE_EN, the pause port SHALL be absent and requests follow REQ-016 unconditionally.

Verification
REQ-028 Reset: reset=0 for 2 cycles -> ball_x=320, ball_y=240, pad_l=pad_r=208, upd_req=0, frame_cnt=0, late_cnt=0.
REQ-029 Normal: FRAME_DIV=1, VS falls with blank=1, ack 5 cycles after upd_req with ball_x_in=100 -> ball_x=100 one cycle after ack, frame_cnt=1, upd_req low, late never pulses.
REQ-030 Divider: FRAME_DIV=3, 6 frame edges, ack each request in blanking -> exactly 2 requests, on the 3rd and 6th edges; frame_cnt=2.
REQ-031 Deadline: never ack, blank falls -> late=1 for one cycle, late_cnt=1, upd_req=0, outputs unchanged; repeat 300 frames with LATE_W=8 -> late_cnt=255.
REQ-032 Collision: upd_ack rises the same cycle blank falls -> no commit, late pulse, late_cnt +1.
REQ-033 Pause (FRAME_SCHED_PAUSE_EN): pause=1 across 4 frame edges -> no upd_req, div_cnt frozen; release -> request on next frame edge.
